// File: rtl/uart_serial_rx.sv
// UART receive front end: synchronizer, half-bit start check, 8 data bits LSB first.
// Define UART_RX_PARITY_EN for 8E1 frames with sticky parity_error; default is 8N1.
module uart_serial_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] clock_divider,
   input  logic        rx,
   input  logic        read_en,
   output logic [7:0]  data_out,
   output logic        data_ready,
   output logic        frame_error,
   output logic        overrun,
   output logic        parity_error,
   output logic        busy
);

   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_WAIT   = 3'd4,
      S_PARITY = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_WAIT  = 3'd4
   } state_t;
`endif

   state_t      r_state;
   logic [SS-1:0] r_sync;
   logic [15:0] r_cnt;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_shift;
   logic [7:0]  r_dout;
   logic        r_ready;
   logic        r_fe;
   logic        r_ovr;
   logic        r_busy;
`ifdef UART_RX_PARITY_EN
   logic        r_par_err;
   logic        r_pe;
`endif

   logic        w_rx_s;
   logic [15:0] w_div;
   logic        w_tick;

   assign w_rx_s = r_sync[SS-1];
   assign w_div  = (clock_divider < 16'd2) ? 16'd2 : clock_divider;
   assign w_tick = (r_cnt <= 16'd1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_sync <= '1;
      else          r_sync <= {r_sync[SS-2:0], rx};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_bitcnt <= 3'd0;
         r_shift  <= 8'h00;
         r_dout   <= 8'h00;
         r_ready  <= 1'b0;
         r_fe     <= 1'b0;
         r_ovr    <= 1'b0;
         r_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err <= 1'b0;
         r_pe      <= 1'b0;
`endif
      end else begin
         // a read clears first; any flag set below in the same cycle wins
         if (read_en) begin
            r_ready <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe    <= 1'b0;
`endif
         end
         if (r_state != S_IDLE && !w_tick)
            r_cnt <= r_cnt - 16'd1;
         unique case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= {1'b0, w_div[15:1]};
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (!w_rx_s) begin
                     r_state  <= S_DATA;
                     r_cnt    <= w_div;
                     r_bitcnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
                     r_par_err <= 1'b0;
`endif
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_shift[r_bitcnt] <= w_rx_s;
                  r_cnt    <= w_div;
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_tick) begin
                  r_par_err <= w_rx_s ^ (^r_shift);
                  r_cnt     <= w_div;
                  r_state   <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (w_tick) begin
                  if (!w_rx_s) begin
                     r_fe    <= 1'b1;
                     r_state <= S_WAIT;
`ifdef UART_RX_PARITY_EN
                  end else if (r_par_err) begin
                     r_pe    <= 1'b1;
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
`endif
                  end else begin
                     if (r_ready && !read_en) begin
                        r_ovr <= 1'b1;
                     end else begin
                        r_dout  <= r_shift;
                        r_ready <= 1'b1;
                     end
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (w_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out    = r_dout;
   assign data_ready  = r_ready;
   assign frame_error = r_fe;
   assign overrun     = r_ovr;
   assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
   assign parity_error = r_pe;
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_serial_rx.sv
// Bench for uart_serial_rx: hand sequences, a vector table and random frames
// checked against a byte-level model of the holding register and flags.
module tb_uart_serial_rx;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] div = 16'd16;
   logic        rx = 1'b1;
   logic        read_en = 1'b0;
   logic [7:0]  data_out;
   logic        data_ready, frame_error, overrun, parity_error, busy;

   uart_serial_rx #(.SYNC_STAGES(2)) dut (
      .clock(clock), .reset_n(reset_n), .clock_divider(div),
      .rx(rx), .read_en(read_en), .data_out(data_out),
      .data_ready(data_ready), .frame_error(frame_error),
      .overrun(overrun), .parity_error(parity_error), .busy(busy)
   );

   always #5 clock = ~clock;

`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
   logic g_pflip = 1'b0;
`else
   localparam int PBITS = 0;
`endif
   // S + 1 + (D>>1) + 9*D for D=16, S=2, one more bit time with parity
   localparam int LAT16 = 2 + 1 + 8 + 9 * 16 + PBITS * 16;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int t_fall = 0;
   int t_rise = -1;
   int lat;
   logic dr_q = 1'b0;

   logic [7:0] m_dout;
   logic m_ready, m_fe, m_ovr, m_pe;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (data_ready && !dr_q) t_rise = cyc;
      dr_q = data_ready;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=0x%0h req=0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: act=%0d req=%0d..%0d", nm, act, lo, hi);
      end
   endtask

   function automatic int deff(input logic [15:0] v);
      return (v < 16'd2) ? 2 : int'(v);
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
      t_fall = cyc;
      rx = 1'b0;
      repeat (d) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (d) @(negedge clock);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ g_pflip;
      repeat (d) @(negedge clock);
`endif
      rx = stop;
      repeat (d) @(negedge clock);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_read();
      read_en = 1'b1;
      @(negedge clock);
      read_en = 1'b0;
      m_ready = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic bad, input logic pf);
      if (bad) m_fe = 1'b1;
      else if (pf) m_pe = 1'b1;
      else if (m_ready) m_ovr = 1'b1;
      else begin
         m_dout = b;
         m_ready = 1'b1;
      end
   endtask

   typedef struct {
      logic [15:0] div;
      logic [7:0]  data;
      logic        stop;
      logic [7:0]  exp_dout;
      logic        exp_ready;
      logic        exp_fe;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{16'd16, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[1] = '{16'd0,  8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[2] = '{16'd1,  8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
      vt[3] = '{16'd3,  8'h81, 1'b1, 8'h81, 1'b1, 1'b0};
      vt[4] = '{16'd7,  8'hC6, 1'b0, 8'h81, 1'b0, 1'b1};
      vt[5] = '{16'd10, 8'h3F, 1'b1, 8'h3F, 1'b1, 1'b0};
      vt[6] = '{16'd33, 8'h96, 1'b1, 8'h96, 1'b1, 1'b0};

      repeat (3) @(negedge clock);
      chk("rst_dout", data_out, 8'h00);
      chk("rst_ready", data_ready, 0);
      chk("rst_fe", frame_error, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_pe", parity_error, 0);
      chk("rst_busy", busy, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // basic frame and latency
      t_rise = -1;
      send_frame(8'h55, 1'b1, 16);
      idle(24);
      chk_rng("latency", t_rise - t_fall, LAT16 - 1, LAT16 + 1);
      chk("b55_dout", data_out, 8'h55);
      chk("b55_ready", data_ready, 1);
      chk("b55_fe", frame_error, 0);
      chk("b55_ovr", overrun, 0);
      chk("b55_pe", parity_error, 0);
      chk("b55_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
      pulse_read();
      g_pflip = 1'b1;
      send_frame(8'h55, 1'b1, 16);
      idle(24);
      g_pflip = 1'b0;
      chk("par_pe", parity_error, 1);
      chk("par_ready", data_ready, 0);
`endif

      // short low glitch rejected by the start check
      pulse_read();
      rx = 1'b0;
      repeat (4) @(negedge clock);
      rx = 1'b1;
      repeat (8) @(negedge clock);
      chk("glitch_busy", busy, 0);
      chk("glitch_ready", data_ready, 0);
      chk("glitch_fe", frame_error, 0);

      // framing error followed by a held-low break
      send_frame(8'hA3, 1'b0, 16);
      repeat (16) @(negedge clock);
      chk("brk_fe", frame_error, 1);
      chk("brk_ready", data_ready, 0);
      chk("brk_busy", busy, 1);
      repeat (32) @(negedge clock);
      idle(24);
      send_frame(8'h3C, 1'b1, 16);
      idle(24);
      chk("brk_dout", data_out, 8'h3C);
      chk("brk_ready2", data_ready, 1);
      chk("brk_fe2", frame_error, 1);
      pulse_read();
      chk("brk_fe_clr", frame_error, 0);
      chk("brk_rdy_clr", data_ready, 0);

      // overrun
      send_frame(8'h11, 1'b1, 16);
      idle(24);
      send_frame(8'h22, 1'b1, 16);
      idle(24);
      chk("ovr_dout", data_out, 8'h11);
      chk("ovr_flag", overrun, 1);
      chk("ovr_ready", data_ready, 1);
      pulse_read();
      chk("ovr_rdy_clr", data_ready, 0);
      chk("ovr_clr", overrun, 0);
      chk("ovr_dout2", data_out, 8'h11);

      // read in the exact acceptance cycle of the next byte
      t_rise = -1;
      send_frame(8'h11, 1'b1, 16);
      idle(24);
      lat = t_rise - t_fall;
      fork
         send_frame(8'h22, 1'b1, 16);
         begin
            repeat (lat - 1) @(negedge clock);
            read_en = 1'b1;
            @(negedge clock);
            read_en = 1'b0;
         end
      join
      idle(24);
      chk("same_dout", data_out, 8'h22);
      chk("same_ready", data_ready, 1);
      chk("same_ovr", overrun, 0);

      // reset during bit 4 of 0xF0
      rx = 1'b0;
      repeat (16) @(negedge clock);
      for (int i = 0; i < 4; i++) repeat (16) @(negedge clock);
      rx = 1'b1;
      repeat (8) @(negedge clock);
      chk("mid_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mrst_dout", data_out, 8'h00);
      chk("mrst_ready", data_ready, 0);
      chk("mrst_fe", frame_error, 0);
      chk("mrst_ovr", overrun, 0);
      chk("mrst_pe", parity_error, 0);
      chk("mrst_busy", busy, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      idle(4);
      send_frame(8'h7E, 1'b1, 16);
      idle(24);
      chk("post_dout", data_out, 8'h7E);
      chk("post_ready", data_ready, 1);
      chk("post_fe", frame_error, 0);
      chk("post_ovr", overrun, 0);

      // vector table
      for (int k = 0; k < 7; k++) begin
         int d;
         pulse_read();
         div = vt[k].div;
         d = deff(vt[k].div);
         send_frame(vt[k].data, vt[k].stop, d);
         idle(d + 8);
         chk($sformatf("vec%0d_dout", k), data_out, vt[k].exp_dout);
         chk($sformatf("vec%0d_ready", k), data_ready, vt[k].exp_ready);
         chk($sformatf("vec%0d_fe", k), frame_error, vt[k].exp_fe);
      end

      // random frames against the byte-level model
      pulse_read();
      m_dout = 8'h96;
      for (int k = 0; k < 20; k++) begin
         logic [7:0] b;
         logic bad, pf;
         int d;
         if ($urandom_range(0, 1) == 0) pulse_read();
         b = 8'($urandom);
         bad = ($urandom_range(0, 5) == 0);
         pf = 1'b0;
`ifdef UART_RX_PARITY_EN
         pf = ($urandom_range(0, 5) == 0);
         g_pflip = pf;
`endif
         d = int'($urandom_range(2, 20));
         div = 16'(d);
         send_frame(b, ~bad, d);
         idle(d + 8);
         model_frame(b, bad, pf);
         chk($sformatf("rnd%0d_dout", k), data_out, m_dout);
         chk($sformatf("rnd%0d_ready", k), data_ready, m_ready);
         chk($sformatf("rnd%0d_fe", k), frame_error, m_fe);
         chk($sformatf("rnd%0d_ovr", k), overrun, m_ovr);
         chk($sformatf("rnd%0d_pe", k), parity_error, m_pe);
         chk($sformatf("rnd%0d_busy", k), busy, 0);
      end
`ifdef UART_RX_PARITY_EN
      g_pflip = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
